instr_ctrl: RTL and testbench

- Instruction fetch/decode controller directly upstream of the execution unit.
- Fetches 32-bit instructions as two 16-bit words from instruction memory and decodes the class field.
- Issues arithmetic work to the execution unit over its ir/sel_eu/cs/ready1 interface and waits for completion.
- Handles jump, NOP and HALT locally.

---
 rtl/instr_ctrl_if.sv | 23 ++
 rtl/instr_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_instr_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_ctrl_if.sv
// rtl/instr_ctrl_if.sv - instruction memory and execution-unit bus bundle for instr_ctrl
interface instr_ctrl_if #(
  parameter int AW = 8
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic          imem_ack;
  logic [31:0]   ir;
  logic [1:0]    sel_eu;
  logic          cs;
  logic          ready1;

  modport master (
    output imem_req, imem_addr, ir, sel_eu, cs,
    input  imem_data, imem_ack, ready1
  );

  modport slave (
    input  imem_req, imem_addr, ir, sel_eu, cs,
    output imem_data, imem_ack, ready1
  );
endinterface

// File: rtl/instr_ctrl.sv
// rtl/instr_ctrl.sv - instruction fetch/decode controller feeding the execution unit
// Optional single-step mode (step port, PAUSE state) is enabled by defining SINGLE_STEP_EN.
module instr_ctrl #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            WAIT_TMO = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef SINGLE_STEP_EN
  input  logic          step,
`endif
  instr_ctrl_if.master  bus,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [1:0]    fault
);

  localparam int CW = $clog2(WAIT_TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(WAIT_TMO - 1);

  localparam logic [3:0] CLS_ARITH_I = 4'h0;
  localparam logic [3:0] CLS_ARITH   = 4'h1;
  localparam logic [3:0] CLS_JMP     = 4'h2;
  localparam logic [3:0] CLS_NOP     = 4'hE;
  localparam logic [3:0] CLS_HALT    = 4'hF;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TMO     = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_HI,
    S_GAP,
    S_FETCH_LO,
    S_DECODE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
`ifdef SINGLE_STEP_EN
    S_PAUSE,
`endif
    S_HALT
  } state_t;

  // Where a finished instruction hands control: straight to the next fetch, or a pause.
`ifdef SINGLE_STEP_EN
  localparam state_t S_NEXT = S_PAUSE;
`else
  localparam state_t S_NEXT = S_FETCH_HI;
`endif

  state_t        state, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [1:0]    sel_q, sel_d;
  logic          cs_q, cs_d;
  logic [1:0]    fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          imem_req_c;
  logic [AW-1:0] imem_addr_c;
`ifdef SINGLE_STEP_EN
  logic          step_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      sel_q   <= 2'b00;
      cs_q    <= 1'b0;
      fault_q <= FAULT_NONE;
      cnt_q   <= '0;
    end else begin
      state   <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sel_q   <= sel_d;
      cs_q    <= cs_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SINGLE_STEP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end
`endif

  always_comb begin
    state_d     = state;
    pc_d        = pc_q;
    ir_d        = ir_q;
    sel_d       = sel_q;
    cs_d        = 1'b0;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    imem_req_c  = 1'b0;
    imem_addr_c = '0;

    case (state)
      S_IDLE: begin
        if (start) state_d = S_FETCH_HI;
      end

      S_FETCH_HI: begin
        imem_req_c  = 1'b1;
        imem_addr_c = pc_q;
        if (bus.imem_ack) begin
          ir_d[31:16] = bus.imem_data;
          state_d     = S_GAP;
        end
      end

      // Request is deliberately low for one cycle between the two words.
      S_GAP: begin
        state_d = S_FETCH_LO;
      end

      S_FETCH_LO: begin
        imem_req_c  = 1'b1;
        imem_addr_c = pc_q + AW'(1);
        if (bus.imem_ack) begin
          ir_d[15:0] = bus.imem_data;
          pc_d       = pc_q + AW'(2);
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        case (ir_q[31:28])
          CLS_ARITH_I: begin
            sel_d   = 2'b00;
            state_d = S_ISSUE;
          end
          CLS_ARITH: begin
            sel_d   = 2'b01;
            state_d = S_ISSUE;
          end
          CLS_JMP: begin
            pc_d    = ir_q[AW-1:0];
            state_d = S_NEXT;
          end
          CLS_NOP:  state_d = S_NEXT;
          CLS_HALT: state_d = S_HALT;
          default: begin
            fault_d = FAULT_ILLEGAL;
            state_d = S_HALT;
          end
        endcase
      end

      S_ISSUE: begin
        if (bus.ready1) begin
          cs_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end
      end

      // An EU that never acknowledges cs by dropping ready1 is treated as dead.
      S_WAIT_BUSY: begin
        if (!bus.ready1) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TMO_LAST) begin
          fault_d = FAULT_TMO;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (bus.ready1) state_d = S_NEXT;
      end

`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (step && !step_q) state_d = S_FETCH_HI;
      end
`endif

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req  = imem_req_c;
  assign bus.imem_addr = imem_addr_c;
  assign bus.ir        = ir_q;
  assign bus.sel_eu    = sel_q;
  assign bus.cs        = cs_q;
  assign pc            = pc_q;
  assign fault         = fault_q;
  assign halted        = (state == S_HALT);
  assign busy          = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_instr_ctrl.sv
// tb/tb_instr_ctrl.sv - directed self-checking bench for instr_ctrl
`timescale 1ns/1ps
module tb_instr_ctrl;
  localparam int AW       = 8;
  localparam int WAIT_TMO = 15;

  localparam int W_CS      = 0;
  localparam int W_EU_BUSY = 1;
  localparam int W_HALT    = 2;
  localparam int W_REQ     = 3;
  localparam int W_ADDR_FF = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
`ifdef SINGLE_STEP_EN
  logic          step  = 1'b0;
`endif
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic [1:0]    fault;

  logic [15:0]   mem [256];
  logic          mem_en   = 1'b1;
  bit            eu_stuck = 1'b0;
  int            eu_t     = -1;
  int            cs_cnt   = 0;
  int            compared   = 0;
  int            mismatched = 0;
  int            n;

  instr_ctrl_if #(.AW(AW)) bus ();

  instr_ctrl #(
    .AW       (AW),
    .RESET_PC (8'h00),
    .WAIT_TMO (WAIT_TMO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef SINGLE_STEP_EN
    .step   (step),
`endif
    .bus    (bus),
    .pc     (pc),
    .busy   (busy),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: ack in the same cycle as the request unless stalled.
  assign bus.imem_ack  = bus.imem_req & mem_en;
  assign bus.imem_data = mem[bus.imem_addr];

  // EU: ready1 falls one cycle after cs is seen and rises six cycles later.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      bus.ready1 = 1'b1;
      eu_t       = -1;
    end else begin
      if (bus.cs) cs_cnt++;
      if (eu_t >= 0) begin
        eu_t++;
        if (eu_t == 1) begin
          bus.ready1 = 1'b0;
        end else if (eu_t == 7) begin
          bus.ready1 = 1'b1;
          eu_t       = -1;
        end
      end else if (bus.cs && !eu_stuck) begin
        eu_t = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d compared / %0d mismatched", compared, mismatched);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond(input int which);
    case (which)
      W_CS:      return bus.cs;
      W_EU_BUSY: return !bus.ready1;
      W_HALT:    return halted;
      W_REQ:     return bus.imem_req;
      W_ADDR_FF: return bus.imem_req && (bus.imem_addr == 8'hFF);
      default:   return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int which, input int lim, input string tag);
    int k = 0;
    while (!cond(which) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(cond(which)), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    start    = 1'b0;
    mem_en   = 1'b1;
    eu_stuck = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0005;
    mem[8'h02] = 16'h1001; mem[8'h03] = 16'h4000;
    mem[8'h04] = 16'h2000; mem[8'h05] = 16'h0010;
    mem[8'h10] = 16'hF000; mem[8'h11] = 16'h0000;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_ir", bus.ir, 32'd0);
    chk("rst_sel_eu", 32'(bus.sel_eu), 32'd0);
    chk("rst_cs", 32'(bus.cs), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_req", 32'(bus.imem_req), 32'd0);

    // arith_i at 0: cycle-exact fetch, decode, issue
    pulse_start();
    chk("a_fhi_req", 32'(bus.imem_req), 32'd1);
    chk("a_fhi_addr", 32'(bus.imem_addr), 32'd0);
    chk("a_fhi_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("a_gap_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    chk("a_flo_req", 32'(bus.imem_req), 32'd1);
    chk("a_flo_addr", 32'(bus.imem_addr), 32'd1);
    @(negedge clk);
    chk("a_dec_ir", bus.ir, 32'h0000_0005);
    chk("a_dec_pc", 32'(pc), 32'd2);
    @(negedge clk);
    chk("a_issue_cs", 32'(bus.cs), 32'd0);
    @(negedge clk);
    chk("a_cs_pulse", 32'(bus.cs), 32'd1);
    chk("a_sel_eu", 32'(bus.sel_eu), 32'd0);
    @(negedge clk);
    chk("a_cs_single", 32'(bus.cs), 32'd0);
    wait_until(W_REQ, 40, "a_next_fetch");
    chk("a_next_addr", 32'(bus.imem_addr), 32'd2);
    chk("a_cs_count", cs_cnt, 32'd1);

    // arith at 2: operands held through the EU-busy window
    wait_until(W_CS, 20, "b_cs_seen");
    chk("b_sel_eu", 32'(bus.sel_eu), 32'd1);
    chk("b_ir", bus.ir, 32'h1001_4000);
    wait_until(W_EU_BUSY, 10, "b_eu_busy");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_ir_hold", bus.ir, 32'h1001_4000);
      chk("b_sel_hold", 32'(bus.sel_eu), 32'd1);
      chk("b_no_cs", 32'(bus.cs), 32'd0);
    end
    wait_until(W_REQ, 20, "b_next_fetch");
    chk("b_next_addr", 32'(bus.imem_addr), 32'd4);
    chk("b_cs_count", cs_cnt, 32'd2);

    // JMP 0x10 then HALT
    wait_until(W_HALT, 40, "c_halted");
    chk("c_pc", 32'(pc), 32'h12);
    chk("c_busy", 32'(busy), 32'd0);
    chk("c_req", 32'(bus.imem_req), 32'd0);
    chk("c_fault", 32'(fault), 32'd0);
    repeat (3) @(negedge clk);
    chk("c_req_later", 32'(bus.imem_req), 32'd0);
    chk("c_halted_later", 32'(halted), 32'd1);
    chk("c_cs_count", cs_cnt, 32'd2);

    // illegal class 0x5
    mem[8'h00] = 16'h5000; mem[8'h01] = 16'h0000;
    do_reset();
    pulse_start();
    wait_until(W_HALT, 20, "d_halted");
    chk("d_fault", 32'(fault), 32'd1);
    chk("d_cs_count", cs_cnt, 32'd2);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("d_start_halted", 32'(halted), 32'd1);
    chk("d_start_busy", 32'(busy), 32'd0);
    chk("d_start_req", 32'(bus.imem_req), 32'd0);
    chk("d_start_pc", 32'(pc), 32'd2);
    chk("d_start_fault", 32'(fault), 32'd1);
    start = 1'b0;

    // EU never drops ready1: timeout fault
    mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0005;
    do_reset();
    eu_stuck = 1'b1;
    pulse_start();
    wait_until(W_CS, 20, "e_cs_seen");
    n = 0;
    while (fault == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("e_tmo_cycles", n, WAIT_TMO);
    chk("e_fault", 32'(fault), 32'd2);
    chk("e_halted", 32'(halted), 32'd1);

    // reset during WAIT_DONE
    mem[8'h00] = 16'h1001; mem[8'h01] = 16'h4000;
    do_reset();
    pulse_start();
    wait_until(W_EU_BUSY, 20, "f_eu_busy");
    @(negedge clk);
    chk("f_pre_sel", 32'(bus.sel_eu), 32'd1);
    chk("f_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("f_rst_ir", bus.ir, 32'd0);
    chk("f_rst_sel", 32'(bus.sel_eu), 32'd0);
    chk("f_rst_cs", 32'(bus.cs), 32'd0);
    chk("f_rst_pc", 32'(pc), 32'd0);
    chk("f_rst_busy", 32'(busy), 32'd0);
    chk("f_rst_req", 32'(bus.imem_req), 32'd0);

    // reset during FETCH_LO with ack stalled
    do_reset();
    pulse_start();
    @(negedge clk);
    mem_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("g_stall_req", 32'(bus.imem_req), 32'd1);
    chk("g_stall_addr", 32'(bus.imem_addr), 32'd1);
    chk("g_stall_ir", bus.ir, 32'h1001_0000);
    rst_n = 1'b0;
    #1;
    chk("g_rst_req", 32'(bus.imem_req), 32'd0);
    chk("g_rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("g_rst_ir", bus.ir, 32'd0);
    chk("g_rst_busy", 32'(busy), 32'd0);
    chk("g_rst_pc", 32'(pc), 32'd0);

    // pc wrap: JMP 0xFE, NOP at 0xFE wraps pc to 0
    mem[8'h00] = 16'h2000; mem[8'h01] = 16'h00FE;
    mem[8'hFE] = 16'hE000; mem[8'hFF] = 16'h0000;
    do_reset();
    pulse_start();
    wait_until(W_ADDR_FF, 30, "h_flo_ff");
    @(negedge clk);
    chk("h_pc_wrap", 32'(pc), 32'd0);
    @(negedge clk);
    chk("h_wrap_req", 32'(bus.imem_req), 32'd1);
    chk("h_wrap_addr", 32'(bus.imem_addr), 32'd0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
